// File: rtl/lz_pkg.sv
// lz_pkg: shared LZ window constants and controller state encoding.
package lz_pkg;
   localparam int LZ_WIN_AW = 9;
   localparam int LZ_WIN_DW = 4;
   localparam int LZ_CNT_W  = 16;
   typedef logic [1:0] lz_state_t;
   localparam lz_state_t ST_IDLE  = 2'd0;
   localparam lz_state_t ST_CLEAR = 2'd1;
   localparam lz_state_t ST_RUN   = 2'd2;
   localparam lz_state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/lz_window_ram.sv
// lz_window_ram: plain 1R1W synchronous-read array; collisions return undefined data.
module lz_window_ram #(
   parameter int AW = 9,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_q;
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_q <= r_mem[i_raddr];
   end
   assign o_rdata = r_q;
endmodule

// File: rtl/lz_window_ctrl.sv
// lz_window_ctrl: LZ history window owner - clear sweep, extractor gating, forwarding, pointer check.
// Host read port enabled by defining LZ_WINDOW_HOST_PORT_EN.
module lz_window_ctrl
   import lz_pkg::*;
#(
   parameter int AW = LZ_WIN_AW,
   parameter int DW = LZ_WIN_DW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   output logic                ext_en,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [LZ_CNT_W-1:0] wr_cnt,
   input  logic                ex_wr_vld,
   input  logic [AW-1:0]       ex_wr_addr,
   input  logic [DW-1:0]       ex_wr_data,
   input  logic [AW-1:0]       ex_rd_addr,
   output logic [DW-1:0]       ex_rd_data,
   input  logic                host_req,
   input  logic [AW-1:0]       host_addr,
   output logic                host_gnt,
   output logic [DW-1:0]       host_rdata,
   output logic                host_rvld
);
   lz_state_t           r_state, w_nxt;
   logic [AW-1:0]       r_clr_cnt, r_exp_ptr;
   logic                r_busy, r_done, r_err, r_fwd, r_rd_ok, r_host_rvld;
   logic [LZ_CNT_W-1:0] r_wr_cnt;
   logic [DW-1:0]       r_fwd_data, w_ram_q, w_rd;
   logic                w_idle_done, w_start_ok, w_clr, w_run, w_wr_run, w_we, w_host_gnt;
   logic [AW-1:0]       w_waddr, w_raddr;
   logic [DW-1:0]       w_wdata;

   assign w_idle_done = (r_state == ST_IDLE) | (r_state == ST_DONE);
   assign w_start_ok  = start & w_idle_done;
   assign w_clr       = r_state == ST_CLEAR;
   assign w_run       = r_state == ST_RUN;
   assign w_wr_run    = w_run & ex_wr_vld;
   assign w_we        = w_clr | w_wr_run;
   assign w_waddr     = w_clr ? r_clr_cnt : ex_wr_addr;
   assign w_wdata     = w_clr ? '0 : ex_wr_data;

   always_comb begin
      w_nxt = w_start_ok                 ? ST_CLEAR :
              (w_clr && &r_clr_cnt)      ? ST_RUN   :
              (w_run && stop)            ? ST_DONE  : r_state;
   end

`ifdef LZ_WINDOW_HOST_PORT_EN
   assign w_raddr    = w_run ? ex_rd_addr : host_addr;
   assign w_host_gnt = host_req & w_idle_done & ~start;
   assign host_rdata = r_host_rvld ? w_rd : '0;
`else
   logic w_unused_host;
   assign w_unused_host = &{1'b0, host_req, host_addr};
   assign w_raddr       = ex_rd_addr;
   assign w_host_gnt    = 1'b0;
   assign host_rdata    = '0;
`endif

   lz_window_ram #(.AW(AW), .DW(DW)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_q)
   );

   // Same-cycle write/read to one address returns the new symbol, not the stale RAM word.
   assign w_rd = r_fwd ? r_fwd_data : w_ram_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_clr_cnt   <= '0;
         r_exp_ptr   <= '0;
         r_wr_cnt    <= '0;
         r_fwd       <= 1'b0;
         r_fwd_data  <= '0;
         r_rd_ok     <= 1'b0;
         r_host_rvld <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         r_busy      <= (w_nxt == ST_CLEAR) | (w_nxt == ST_RUN);
         r_done      <= w_run & stop;
         r_clr_cnt   <= w_clr ? r_clr_cnt + 1'b1 : '0;
         r_exp_ptr   <= w_clr ? '0 : w_wr_run ? r_exp_ptr + 1'b1 : r_exp_ptr;
         r_err       <= w_start_ok ? 1'b0 : (w_wr_run && ex_wr_addr != r_exp_ptr) ? 1'b1 : r_err;
         r_wr_cnt    <= w_start_ok ? '0 : (w_wr_run && ~&r_wr_cnt) ? r_wr_cnt + 1'b1 : r_wr_cnt;
         r_fwd       <= w_we & (w_waddr == w_raddr);
         r_fwd_data  <= w_wdata;
         r_rd_ok     <= 1'b1;
         r_host_rvld <= w_host_gnt;
      end
   end

   assign ext_en     = w_run;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign wr_cnt     = r_wr_cnt;
   assign ex_rd_data = r_rd_ok ? w_rd : '0;
   assign host_gnt   = w_host_gnt;
   assign host_rvld  = r_host_rvld;
endmodule

// File: tb/tb_lz_window_ctrl.sv
// tb_lz_window_ctrl: directed bench for lz_window_ctrl (host checks follow LZ_WINDOW_HOST_PORT_EN).
module tb_lz_window_ctrl;
   logic        clk, rst_n, start, stop, ext_en, busy, done, err;
   logic [15:0] wr_cnt;
   logic        ex_wr_vld, host_req, host_gnt, host_rvld;
   logic [8:0]  ex_wr_addr, ex_rd_addr, host_addr;
   logic [3:0]  ex_wr_data, ex_rd_data, host_rdata;
   int          n_vec = 0, n_err = 0;

   lz_window_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ext_en(ext_en), .busy(busy),
      .done(done), .err(err), .wr_cnt(wr_cnt), .ex_wr_vld(ex_wr_vld), .ex_wr_addr(ex_wr_addr),
      .ex_wr_data(ex_wr_data), .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data),
      .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
      .host_rdata(host_rdata), .host_rvld(host_rvld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [8:0] a, input logic [3:0] d);
      ex_wr_vld = 1'b1; ex_wr_addr = a; ex_wr_data = d;
      tick();
      ex_wr_vld = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; stop = 0; ex_wr_vld = 0; ex_wr_addr = 0; ex_wr_data = 0;
      ex_rd_addr = 0; host_req = 0; host_addr = 0;
      repeat (3) tick();
      n_vec++;
      if ({ext_en, busy, done, err, wr_cnt, host_gnt, host_rvld, host_rdata, ex_rd_data} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want all zero",
                  {ext_en, busy, done, err, wr_cnt, host_gnt, host_rvld, host_rdata, ex_rd_data});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_run();
      int n = 0;
      while (!ext_en && n < 600) begin tick(); n++; end
      n_vec++;
      if (n !== 512) begin n_err++; $display("FAIL ext_en_latency: got %0d want 512 cycles after start edge", n); end
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL busy_in_run: got %b want 1", busy); end
   endtask

   task automatic run_start();
      start = 1'b1; tick(); start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || ext_en !== 1'b0) begin
         n_err++; $display("FAIL clear_entry: got busy=%b ext_en=%b want busy=1 ext_en=0", busy, ext_en);
      end
      wait_run();
   endtask

   task automatic test_sweep_zero();
      for (int a = 0; a < 512; a++) begin
         ex_rd_addr = 9'(a);
         tick();
         n_vec++;
         if (ex_rd_data !== 4'h0) begin n_err++; $display("FAIL clear_sweep[%0d]: got %h want 0", a, ex_rd_data); end
      end
   endtask

   task automatic test_write_read();
      wr(9'd0, 4'h5);
      wr(9'd1, 4'hA);
      ex_rd_addr = 9'd0; tick();
      n_vec++;
      if (ex_rd_data !== 4'h5) begin n_err++; $display("FAIL read_addr0: got %h want 5", ex_rd_data); end
      ex_rd_addr = 9'd1; tick();
      n_vec++;
      if (ex_rd_data !== 4'hA) begin n_err++; $display("FAIL read_addr1: got %h want a", ex_rd_data); end
      n_vec++;
      if (err !== 1'b0 || wr_cnt !== 16'd2) begin
         n_err++; $display("FAIL after_two_writes: got err=%b wr_cnt=%0d want err=0 wr_cnt=2", err, wr_cnt);
      end
   endtask

   task automatic test_collision();
      wr(9'd2, 4'h1);
      ex_rd_addr = 9'd3; wr(9'd3, 4'hC);
      n_vec++;
      if (ex_rd_data !== 4'hC) begin n_err++; $display("FAIL collision_fwd: got %h want c", ex_rd_data); end
      tick();
      n_vec++;
      if (ex_rd_data !== 4'hC) begin n_err++; $display("FAIL collision_stored: got %h want c", ex_rd_data); end
      ex_rd_addr = 9'd1; wr(9'd4, 4'h9);
      n_vec++;
      if (ex_rd_data !== 4'hA) begin n_err++; $display("FAIL no_false_fwd: got %h want a", ex_rd_data); end
      n_vec++;
      if (err !== 1'b0 || wr_cnt !== 16'd5) begin
         n_err++; $display("FAIL after_collision: got err=%b wr_cnt=%0d want err=0 wr_cnt=5", err, wr_cnt);
      end
   endtask

   task automatic test_stop(input logic exp_err);
      stop = 1'b1; tick(); stop = 1'b0;
      n_vec++;
      if (done !== 1'b1 || ext_en !== 1'b0 || busy !== 1'b0 || err !== exp_err) begin
         n_err++;
         $display("FAIL stop_entry: got done=%b ext_en=%b busy=%b err=%b want 1 0 0 %b", done, ext_en, busy, err, exp_err);
      end
      stop = 1'b1; tick(); stop = 1'b0;
      n_vec++;
      if (done !== 1'b0 || err !== exp_err) begin
         n_err++; $display("FAIL done_pulse: got done=%b err=%b want done=0 err=%b", done, err, exp_err);
      end
   endtask

   task automatic test_done_ignore();
      ex_rd_addr = 9'd0; host_addr = 9'd0;
      wr(9'd0, 4'hF);
      tick();
      n_vec++;
      if (ex_rd_data !== 4'h5 || wr_cnt !== 16'd5) begin
         n_err++; $display("FAIL done_write_ignored: got data=%h wr_cnt=%0d want data=5 wr_cnt=5", ex_rd_data, wr_cnt);
      end
   endtask

   task automatic test_host();
      host_req = 1'b1; host_addr = 9'd3;
      #1;
`ifdef LZ_WINDOW_HOST_PORT_EN
      n_vec++;
      if (host_gnt !== 1'b1) begin n_err++; $display("FAIL host_gnt: got %b want 1", host_gnt); end
      tick(); host_req = 1'b0;
      n_vec++;
      if (host_rvld !== 1'b1 || host_rdata !== 4'hC) begin
         n_err++; $display("FAIL host_read: got rvld=%b data=%h want rvld=1 data=c", host_rvld, host_rdata);
      end
      tick();
      n_vec++;
      if (host_rvld !== 1'b0) begin n_err++; $display("FAIL host_rvld_pulse: got %b want 0", host_rvld); end
`else
      n_vec++;
      if (host_gnt !== 1'b0) begin n_err++; $display("FAIL host_gnt_off: got %b want 0", host_gnt); end
      tick(); host_req = 1'b0;
      n_vec++;
      if (host_rvld !== 1'b0 || host_rdata !== 4'h0) begin
         n_err++; $display("FAIL host_off: got rvld=%b data=%h want 0 0", host_rvld, host_rdata);
      end
`endif
   endtask

   task automatic test_start_priority();
      host_req = 1'b1; start = 1'b1; host_addr = 9'd3;
      #1;
      n_vec++;
      if (host_gnt !== 1'b0) begin n_err++; $display("FAIL start_over_host: got gnt=%b want 0", host_gnt); end
      tick(); start = 1'b0; host_req = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || host_rvld !== 1'b0 || wr_cnt !== 16'd0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL start_clear: got busy=%b rvld=%b wr_cnt=%0d err=%b want 1 0 0 0", busy, host_rvld, wr_cnt, err);
      end
      wait_run();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 512; i++) wr(9'(i), 4'(i));
      wr(9'd0, 4'hF);
      n_vec++;
      if (err !== 1'b0 || wr_cnt !== 16'd513) begin
         n_err++; $display("FAIL wrap: got err=%b wr_cnt=%0d want err=0 wr_cnt=513", err, wr_cnt);
      end
      wr(9'd5, 4'h2);
      n_vec++;
      if (err !== 1'b1 || wr_cnt !== 16'd514) begin
         n_err++; $display("FAIL ptr_mismatch: got err=%b wr_cnt=%0d want err=1 wr_cnt=514", err, wr_cnt);
      end
      ex_rd_addr = 9'd0; tick();
      n_vec++;
      if (ex_rd_data !== 4'hF) begin n_err++; $display("FAIL wrap_read0: got %h want f", ex_rd_data); end
      ex_rd_addr = 9'd7; tick();
      n_vec++;
      if (ex_rd_data !== 4'h7) begin n_err++; $display("FAIL wrap_read7: got %h want 7", ex_rd_data); end
      wr(9'd6, 4'h3);
      n_vec++;
      if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; tick(); start = 1'b0;
      repeat (200) tick();
      n_vec++;
      if (busy !== 1'b1 || ext_en !== 1'b0) begin
         n_err++; $display("FAIL mid_clear: got busy=%b ext_en=%b want 1 0", busy, ext_en);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({ext_en, busy, done, err, wr_cnt, host_gnt, host_rvld, host_rdata, ex_rd_data} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got %b want all zero",
                  {ext_en, busy, done, err, wr_cnt, host_gnt, host_rvld, host_rdata, ex_rd_data});
      end
      tick(); rst_n = 1'b1;
      repeat (3) tick();
      n_vec++;
      if (busy !== 1'b0 || ext_en !== 1'b0) begin
         n_err++; $display("FAIL idle_after_reset: got busy=%b ext_en=%b want 0 0", busy, ext_en);
      end
      run_start();
      test_sweep_zero();
   endtask

   initial begin
      test_reset();
      run_start();
      test_sweep_zero();
      test_write_read();
      test_collision();
      test_stop(1'b0);
      test_done_ignore();
      test_host();
      test_start_priority();
      test_wrap();
      test_stop(1'b1);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
